// File: rtl/life_pkg.sv
// Shared op-codes and sequencer state encoding for the Life generation controller.
package life_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_STEP  = 3'd2;
    localparam logic [2:0] OP_RUN   = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLEAR,
        ST_WAIT,
        ST_PULSE
    } state_t;

endpackage

// File: rtl/life_prescaler.sv
// Generation-period prescaler: holds the reload value and counts down between
// enables. expire flags the last WAIT cycle so the pulse lands exactly rate+1 apart.
module life_prescaler #(
    parameter int RATE_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [RATE_W-1:0] load_val,
    input  logic              reload,
    input  logic              count,
    input  logic              clear,
    output logic              expire,
    output logic              zero_rate
);

    logic [RATE_W-1:0] reload_reg;
    logic [RATE_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_reg <= '0;
            cnt_reg    <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (load) begin
            reload_reg <= load_val;
            cnt_reg    <= load_val;
        end else if (reload) begin
            cnt_reg <= reload_reg;
        end else if (count && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - RATE_W'(1);
        end
    end

    // A count of 1 means the enable must be registered on this edge.
    assign expire    = (cnt_reg <= RATE_W'(1));
    assign zero_rate = (reload_reg == '0);

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation sequencer for the Life cell array: accepts host commands and drives
// the array's write enables, row/val bus, scan clear and paced generation enable.
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int COLS   = 4,
    parameter int RATE_W = 24,
    parameter int CNT_W  = 16,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [CW-1:0]     cmd_col,
    input  logic [1:0]        cmd_row,
    input  logic              cmd_val,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [RATE_W-1:0] rate,
    input  logic              stop,
    output logic [COLS-1:0]   write_enb,
    output logic [1:0]        row,
    output logic              val,
    output logic              scan,
    output logic              enable,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  gen_count
);

    state_t            state_reg, state_next;
    logic [COLS-1:0]   write_enb_reg, write_enb_next;
    logic [1:0]        row_reg, row_next;
    logic              val_reg, val_next;
    logic              scan_reg, scan_next;
    logic              enable_reg, enable_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [CNT_W-1:0]  gen_count_reg, gen_count_next;
    logic [CNT_W-1:0]  remain_reg, remain_next;
    logic              run_reg, run_next;

    logic              ps_load, ps_reload, ps_count, ps_clear;
    logic              ps_expire, ps_zero_rate;
    logic [COLS-1:0]   col_onehot;

    // Out-of-range columns match no bit, so the write is swallowed.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign col_onehot[gi] = (cmd_col == CW'(gi));
    end

    life_prescaler #(
        .RATE_W (RATE_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (reset),
        .load      (ps_load),
        .load_val  (rate),
        .reload    (ps_reload),
        .count     (ps_count),
        .clear     (ps_clear),
        .expire    (ps_expire),
        .zero_rate (ps_zero_rate)
    );

    always_comb begin
        state_next     = state_reg;
        write_enb_next = '0;
        row_next       = row_reg;
        val_next       = val_reg;
        scan_next      = 1'b0;
        enable_next    = 1'b0;
        done_next      = 1'b0;
        gen_count_next = gen_count_reg;
        remain_next    = remain_reg;
        run_next       = run_reg;
        ps_load        = 1'b0;
        ps_reload      = 1'b0;
        ps_count       = 1'b0;
        ps_clear       = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            state_next     = ST_WRITE;
                            row_next       = cmd_row;
                            val_next       = cmd_val;
                            write_enb_next = col_onehot;
                        end
                        OP_CLEAR: begin
                            state_next     = ST_CLEAR;
                            scan_next      = 1'b1;
                            gen_count_next = '0;
                        end
                        OP_STEP, OP_RUN: begin
                            run_next    = (cmd_op == OP_RUN);
                            remain_next = cmd_count;
                            ps_load     = 1'b1;
                            if (cmd_op == OP_STEP && cmd_count == '0) begin
                                done_next = 1'b1;
                            end else if (rate == '0) begin
                                state_next     = ST_PULSE;
                                enable_next    = 1'b1;
                                gen_count_next = gen_count_reg + CNT_W'(1);
                            end else begin
                                state_next = ST_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WRITE, ST_CLEAR: begin
                state_next = ST_IDLE;
            end
            ST_WAIT: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    ps_clear   = 1'b1;
                end else if (ps_expire) begin
                    state_next     = ST_PULSE;
                    enable_next    = 1'b1;
                    gen_count_next = gen_count_reg + CNT_W'(1);
                end else begin
                    ps_count = 1'b1;
                end
            end
            ST_PULSE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    ps_clear   = 1'b1;
                end else if (!run_reg && remain_reg <= CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    if (!run_reg) begin
                        remain_next = remain_reg - CNT_W'(1);
                    end
                    ps_reload = 1'b1;
                    if (ps_zero_rate) begin
                        enable_next    = 1'b1;
                        gen_count_next = gen_count_reg + CNT_W'(1);
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            write_enb_reg <= '0;
            row_reg       <= '0;
            val_reg       <= 1'b0;
            scan_reg      <= 1'b0;
            enable_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            gen_count_reg <= '0;
            remain_reg    <= '0;
            run_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            write_enb_reg <= write_enb_next;
            row_reg       <= row_next;
            val_reg       <= val_next;
            scan_reg      <= scan_next;
            enable_reg    <= enable_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            gen_count_reg <= gen_count_next;
            remain_reg    <= remain_next;
            run_reg       <= run_next;
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign write_enb = write_enb_reg;
    assign row       = row_reg;
    assign val       = val_reg;
    assign scan      = scan_reg;
    assign enable    = enable_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign gen_count = gen_count_reg;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl: a timeline model predicts every output each
// cycle from the command timing rules; literal checks pin key cycles.
module tb_life_gen_ctrl;

    localparam int COLS   = 5;
    localparam int CW     = 3;
    localparam int RATE_W = 24;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 4096;

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_WRITE = 3'd1;
    localparam logic [2:0] C_STEP  = 3'd2;
    localparam logic [2:0] C_RUN   = 3'd3;
    localparam logic [2:0] C_CLEAR = 3'd4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [CW-1:0]     cmd_col = '0;
    logic [1:0]        cmd_row = '0;
    logic              cmd_val = 1'b0;
    logic [CNT_W-1:0]  cmd_count = '0;
    logic [RATE_W-1:0] rate = '0;
    logic              stop = 1'b0;
    logic [COLS-1:0]   write_enb;
    logic [1:0]        row;
    logic              val;
    logic              scan;
    logic              enable;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  gen_count;

    life_gen_ctrl #(
        .COLS   (COLS),
        .RATE_W (RATE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .cmd_val   (cmd_val),
        .cmd_count (cmd_count),
        .rate      (rate),
        .stop      (stop),
        .write_enb (write_enb),
        .row       (row),
        .val       (val),
        .scan      (scan),
        .enable    (enable),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             enable;
        logic             scan;
        logic             done;
        logic             busy;
        logic             ready;
        logic             val;
        logic [COLS-1:0]  we;
        logic [1:0]       row;
        logic [CNT_W-1:0] gen;
    } exp_t;

    exp_t             exp_q [DEPTH];
    int               cyc = 0;
    int               filled_upto = -1;
    int               last_busy = -1;
    bit               in_reset = 1'b1;
    logic [CNT_W-1:0] model_gen = '0;
    logic [1:0]       model_row = '0;
    logic             model_val = 1'b0;
    int               checks = 0;
    int               errors = 0;
    int               en_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.enable = 1'b0;
        e.scan   = 1'b0;
        e.done   = 1'b0;
        e.busy   = 1'b0;
        e.ready  = 1'b1;
        e.val    = model_val;
        e.we     = '0;
        e.row    = model_row;
        e.gen    = model_gen;
        return e;
    endfunction

    task automatic put(input int idx, input exp_t e);
        if (idx >= 0 && idx < DEPTH) exp_q[idx] = e;
    endtask

    // Enables fall at k = (rate+1), 2(rate+1), ... after acceptance; a STEP of n
    // ends one cycle after its n-th enable, a stop at edge t+s ends at t+s+1.
    task automatic model_gen_cmd(input int a, input int rt, input int n, input bit is_run,
                                 input int stop_at);
        int   endc;
        exp_t e;
        if (!is_run && n == 0) endc = 1;
        else if (!is_run)      endc = (rt + 1) * n + 1;
        else                   endc = 1 << 30;
        if (stop_at > 0 && stop_at + 1 < endc) endc = stop_at + 1;
        for (int k = 1; k < endc; k++) begin
            e = idle_exp();
            e.busy  = 1'b1;
            e.ready = 1'b0;
            e.enable = ((k % (rt + 1)) == 0);
            if (e.enable) model_gen = model_gen + CNT_W'(1);
            e.gen = model_gen;
            put(a + k - 1, e);
        end
        e = idle_exp();
        e.done = 1'b1;
        put(a + endc - 1, e);
        filled_upto = a + endc - 1;
        last_busy   = a + endc - 2;
    endtask

    task automatic issue(input logic [2:0] op, input int col, input int rw, input int v,
                         input int cnt, input int rt, input int stop_at, input bit drive_stop,
                         output int a);
        exp_t e;
        @(negedge clk);
        while (cyc <= last_busy) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_col   = CW'(col);
        cmd_row   = 2'(rw);
        cmd_val   = v[0];
        cmd_count = CNT_W'(cnt);
        rate      = RATE_W'(rt);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        a = cyc;
        $display("CMD op=%0d col=%0d row=%0d val=%0d count=%0d rate=%0d accepted, first cycle %0d",
                 op, col, rw, v, cnt, rt, a);
        case (op)
            C_WRITE: begin
                model_row = 2'(rw);
                model_val = v[0];
                e = idle_exp();
                e.busy  = 1'b1;
                e.ready = 1'b0;
                e.we    = (col < COLS) ? COLS'(1 << col) : '0;
                put(a, e);
                filled_upto = a;
                last_busy   = a;
            end
            C_CLEAR: begin
                model_gen = '0;
                e = idle_exp();
                e.busy  = 1'b1;
                e.ready = 1'b0;
                e.scan  = 1'b1;
                put(a, e);
                filled_upto = a;
                last_busy   = a;
            end
            C_STEP:  model_gen_cmd(a, rt, cnt, 1'b0, stop_at);
            C_RUN:   model_gen_cmd(a, rt, cnt, 1'b1, stop_at);
            default: last_busy = a - 1;
        endcase
        if (drive_stop && stop_at > 0) begin
            @(negedge clk);
            repeat (stop_at - 1) @(negedge clk);
            stop = 1'b1;
            @(posedge clk);
            #1 stop = 1'b0;
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        while (cyc <= last_busy) @(negedge clk);
    endtask

    // Per-cycle comparison against the timeline model.
    always @(negedge clk) begin
        exp_t e;
        if (in_reset) begin
            e = idle_exp();
            e.row = '0;
            e.val = 1'b0;
            e.gen = '0;
        end else if (cyc <= filled_upto && cyc >= 0 && cyc < DEPTH) begin
            e = exp_q[cyc];
        end else begin
            e = idle_exp();
        end
        chk("enable", 32'(enable), 32'(e.enable));
        chk("scan", 32'(scan), 32'(e.scan));
        chk("done", 32'(done), 32'(e.done));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("cmd_ready", 32'(cmd_ready), 32'(e.ready));
        chk("write_enb", 32'(write_enb), 32'(e.we));
        chk("row", 32'(row), 32'(e.row));
        chk("val", 32'(val), 32'(e.val));
        chk("gen_count", 32'(gen_count), 32'(e.gen));
        if (!in_reset && enable === 1'b1) en_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int en0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_gen", 32'(gen_count), 32'd0);
        #2 reset = 1'b0;
        in_reset = 1'b0;

        // WRITE col=2 row=3 val=1, stop held high and ignored
        stop = 1'b1;
        issue(C_WRITE, 2, 3, 1, 0, 0, 0, 1'b0, a);
        @(negedge clk);
        chk("wr_we_t1", 32'(write_enb), 32'h04);
        chk("wr_row_t1", 32'(row), 32'd3);
        chk("wr_ready_t1", 32'(cmd_ready), 32'd0);
        stop = 1'b0;
        @(negedge clk);
        chk("wr_ready_t2", 32'(cmd_ready), 32'd1);
        chk("wr_we_t2", 32'(write_enb), 32'h00);

        // stop while idle has no effect
        stop = 1'b1;
        repeat (3) @(negedge clk);
        stop = 1'b0;

        // STEP 3 at rate 0: back-to-back enables
        en0 = en_seen;
        issue(C_STEP, 0, 0, 0, 3, 0, 0, 1'b0, a);
        @(negedge clk);
        chk("step3_en_t1", 32'(enable), 32'd1);
        wait_idle();
        chk("step3_gen", 32'(gen_count), 32'd3);
        chk("step3_nen", 32'(en_seen - en0), 32'd3);

        // STEP 2 at rate 4: enables at t+5, t+10, done at t+11
        en0 = en_seen;
        issue(C_STEP, 0, 0, 0, 2, 4, 0, 1'b0, a);
        repeat (11) @(negedge clk);
        chk("step2_done_t11", 32'(done), 32'd1);
        wait_idle();
        chk("step2_gen", 32'(gen_count), 32'd5);
        chk("step2_nen", 32'(en_seen - en0), 32'd2);

        // STEP 0: immediate done, no enable
        issue(C_STEP, 0, 0, 0, 0, 7, 0, 1'b0, a);
        @(negedge clk);
        chk("step0_done_t1", 32'(done), 32'd1);
        chk("step0_en_t1", 32'(enable), 32'd0);

        // RUN rate 1, stop on the third expiry edge (t+5)
        en0 = en_seen;
        issue(C_RUN, 0, 0, 0, 0, 1, 5, 1'b1, a);
        @(negedge clk);
        chk("run_done", 32'(done), 32'd1);
        wait_idle();
        repeat (4) @(negedge clk);
        chk("run_nen", 32'(en_seen - en0), 32'd2);
        chk("run_gen", 32'(gen_count), 32'd7);

        // STEP 5 rate 3 stopped mid-WAIT at edge t+6
        issue(C_STEP, 0, 0, 0, 5, 3, 6, 1'b1, a);
        wait_idle();
        chk("stepstop_gen", 32'(gen_count), 32'd8);

        // CLEAR, then out-of-range writes and ignored op-codes
        issue(C_CLEAR, 0, 0, 0, 0, 0, 0, 1'b0, a);
        @(negedge clk);
        chk("clr_scan_t1", 32'(scan), 32'd1);
        chk("clr_gen_t1", 32'(gen_count), 32'd0);
        issue(C_WRITE, 5, 1, 0, 0, 0, 0, 1'b0, a);
        issue(C_WRITE, 7, 2, 1, 0, 0, 0, 1'b0, a);
        issue(C_WRITE, 4, 0, 1, 0, 0, 0, 1'b0, a);
        issue(C_NOP, 0, 0, 0, 0, 0, 0, 1'b0, a);
        issue(3'd6, 0, 0, 0, 0, 0, 0, 1'b0, a);
        wait_idle();

        // RUN at rate 2 interrupted by asynchronous reset
        issue(C_RUN, 0, 0, 0, 0, 2, 60, 1'b0, a);
        repeat (7) @(negedge clk);
        #2;
        reset = 1'b1;
        in_reset = 1'b1;
        #1;
        chk("arst_enable", 32'(enable), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_gen", 32'(gen_count), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_gen = '0;
        model_row = '0;
        model_val = 1'b0;
        filled_upto = -1;
        last_busy = -1;
        in_reset = 1'b0;

        en0 = en_seen;
        issue(C_STEP, 0, 0, 0, 2, 1, 0, 1'b0, a);
        wait_idle();
        chk("post_rst_gen", 32'(gen_count), 32'd2);
        chk("post_rst_nen", 32'(en_seen - en0), 32'd2);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
